// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, fetches words over a variable-latency
// req/ready memory port, and hands them one at a time to the datapath.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        iszero,
  input  logic        branch_en,
  input  logic        branch_ne,
  input  logic        jump_en,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       instr_pc_q, instr_pc_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  // Branch displacement: sign-extended word offset, scaled to bytes.
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    logic signed [31:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return off;
  endfunction

  function automatic logic [31:0] calc_next_pc(
    input logic [31:0] pc,
    input logic [31:0] ins,
    input logic        j,
    input logic        b,
    input logic        ne,
    input logic        z
  );
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    if (j) begin
      return {pc4[31:28], ins[25:0], 2'b00};
    end else if (b && (z ^ ne)) begin
      return pc4 + $unsigned(branch_offset(ins[15:0]));
    end
    return pc4;
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        state_d = REQ;
        cnt_d   = '0;
      end
      REQ: begin
        // A response on the final allowed cycle still counts as on time.
        if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = VALID;
        end else if (cnt_inc == CNT_MAX) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      VALID: begin
        if (instr_ready) begin
          pc_d    = calc_next_pc(instr_pc_q, instr_q, jump_en, branch_en,
                                 branch_ne, iszero);
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, multi-cycle
// corner sequences, and randomized fetches against a next-PC reference model.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        iszero;
  logic        branch_en;
  logic        branch_ne;
  logic        jump_en;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  localparam longint M32 = 64'sh1_0000_0000;

  ifetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .iszero     (iszero),
    .branch_en  (branch_en),
    .branch_ne  (branch_ne),
    .jump_en    (jump_en),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  // Next PC straight from the architectural rules, using integer arithmetic.
  function automatic logic [31:0] ref_next(logic [31:0] pc, logic [31:0] w,
                                           logic j, logic b, logic ne, logic z);
    longint p4, off, r;
    p4 = (longint'(pc) + 4) % M32;
    if (j) begin
      r = (p4 / 268435456) * 268435456 + longint'(w % 32'h0400_0000) * 4;
    end else if (b && (z != ne)) begin
      off = longint'(w[15:0]);
      if (off >= 32768) off = off - 65536;
      r = p4 + off * 4;
      if (r < 0) r = r + M32;
      r = r % M32;
    end else begin
      r = p4;
    end
    return r[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_ctl();
    jump_en   = 1'($urandom);
    branch_en = 1'($urandom);
    branch_ne = 1'($urandom);
    iszero    = 1'($urandom);
  endtask

  // One complete fetch: optional wait states, optional consumer stall, then
  // the handshake with the given controls; ends in the next REQ cycle.
  task automatic deliver(input string tag, input logic [31:0] word,
                         input int waits, input int hold,
                         input logic j, input logic b, input logic ne, input logic z,
                         input logic [31:0] exp_addr, input logic [31:0] exp_next);
    int guard;
    logic [31:0] addr;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 8) begin
      step();
      guard++;
    end
    chk({tag, " req"}, {31'b0, imem_req}, 32'd1);
    addr = imem_addr;
    chk({tag, " addr"}, addr, exp_addr);
    chk({tag, " align"}, {30'b0, addr[1:0]}, 32'd0);
    chk({tag, " valid_in_req"}, {31'b0, instr_valid}, 32'd0);
    for (int w = 0; w < waits; w++) begin
      imem_ready  = 1'b0;
      imem_rdata  = $urandom;
      instr_ready = 1'($urandom);
      junk_ctl();
      step();
      chk({tag, " req_wait"}, {31'b0, imem_req}, 32'd1);
      chk({tag, " valid_wait"}, {31'b0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    step();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk({tag, " valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, " instr"}, instr, word);
    chk({tag, " instr_pc"}, instr_pc, addr);
    chk({tag, " req_in_valid"}, {31'b0, imem_req}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      instr_ready = 1'b0;
      imem_ready  = 1'($urandom);
      imem_rdata  = $urandom;
      junk_ctl();
      step();
      chk({tag, " hold_valid"}, {31'b0, instr_valid}, 32'd1);
      chk({tag, " hold_instr"}, instr, word);
      chk({tag, " hold_pc"}, instr_pc, addr);
      chk({tag, " hold_noreq"}, {31'b0, imem_req}, 32'd0);
    end
    imem_ready  = 1'b0;
    instr_ready = 1'b1;
    jump_en     = j;
    branch_en   = b;
    branch_ne   = ne;
    iszero      = z;
    step();
    instr_ready = 1'b0;
    junk_ctl();
    chk({tag, " valid_drop"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, " next_req"}, {31'b0, imem_req}, 32'd1);
    chk({tag, " next_pc"}, imem_addr, exp_next);
  endtask

  typedef struct {
    string       name;
    logic [31:0] word;
    int          waits;
    int          hold;
    logic        j, b, ne, z;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] mpc, w, nxt;
    logic rj, rb, rne, rz;

    vecs[0]  = '{"seq0",   32'hC0DE_0000, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{"seq1",   32'hC0DE_0004, 0, 0, 0, 0, 0, 0, 32'h0000_0004, 32'h0000_0008};
    vecs[2]  = '{"stall5", 32'hC0DE_0008, 0, 5, 0, 0, 0, 0, 32'h0000_0008, 32'h0000_000C};
    vecs[3]  = '{"wait3",  32'hC0DE_000C, 3, 0, 0, 0, 0, 0, 32'h0000_000C, 32'h0000_0010};
    vecs[4]  = '{"beq_t",  32'h1000_FFFE, 0, 0, 0, 1, 0, 1, 32'h0000_0010, 32'h0000_000C};
    vecs[5]  = '{"j_back", 32'h0800_0004, 0, 0, 1, 0, 0, 0, 32'h0000_000C, 32'h0000_0010};
    vecs[6]  = '{"beq_nt", 32'h1000_FFFE, 0, 0, 0, 1, 0, 0, 32'h0000_0010, 32'h0000_0014};
    vecs[7]  = '{"j_back2",32'h0800_0004, 0, 0, 1, 0, 0, 0, 32'h0000_0014, 32'h0000_0010};
    vecs[8]  = '{"bne_t",  32'h1400_FFFE, 0, 0, 0, 1, 1, 0, 32'h0000_0010, 32'h0000_000C};
    vecs[9]  = '{"bne_nt", 32'h1400_FFFE, 0, 0, 0, 1, 1, 1, 32'h0000_000C, 32'h0000_0010};
    vecs[10] = '{"j_top0", 32'h0BFF_FFFF, 0, 0, 1, 0, 0, 0, 32'h0000_0010, 32'h0FFF_FFFC};
    vecs[11] = '{"seq_r1", 32'hC0DE_0011, 0, 0, 0, 0, 0, 0, 32'h0FFF_FFFC, 32'h1000_0000};
    vecs[12] = '{"j_top1", 32'h0BFF_FFFF, 0, 0, 1, 0, 0, 0, 32'h1000_0000, 32'h1FFF_FFFC};
    vecs[13] = '{"seq_r2", 32'hC0DE_0013, 0, 0, 0, 0, 0, 0, 32'h1FFF_FFFC, 32'h2000_0000};
    vecs[14] = '{"j_top2", 32'h0BFF_FFFF, 1, 1, 1, 0, 0, 0, 32'h2000_0000, 32'h2FFF_FFFC};
    vecs[15] = '{"seq_r3", 32'hC0DE_0015, 0, 0, 0, 0, 0, 0, 32'h2FFF_FFFC, 32'h3000_0000};
    vecs[16] = '{"j_prio", 32'h0800_0040, 0, 0, 1, 1, 0, 1, 32'h3000_0000, 32'h3000_0100};
    vecs[17] = '{"b_maxfw",32'h1000_7FFF, 0, 0, 0, 1, 0, 1, 32'h3000_0100, 32'h3002_0100};

    rst = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;
    iszero = 1'b0;
    branch_en = 1'b0;
    branch_ne = 1'b0;
    jump_en = 1'b0;

    step();
    step();
    chk("rst valid", {31'b0, instr_valid}, 32'd0);
    chk("rst req", {31'b0, imem_req}, 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst instr_pc", instr_pc, 32'd0);
    chk("rst err", {31'b0, fetch_err}, 32'd0);

    rst = 1'b1;
    step();
    chk("req_after_release", {31'b0, imem_req}, 32'd1);
    chk("addr_after_release", imem_addr, 32'd0);

    foreach (vecs[i]) begin
      deliver(vecs[i].name, vecs[i].word, vecs[i].waits, vecs[i].hold,
              vecs[i].j, vecs[i].b, vecs[i].ne, vecs[i].z,
              vecs[i].exp_addr, vecs[i].exp_next);
    end
    chk("err_still_clear", {31'b0, fetch_err}, 32'd0);

    // Timeout: four unanswered REQ cycles, one IDLE, then retry of same pc.
    mpc = 32'h3002_0100;
    imem_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("to_req_wait", {31'b0, imem_req}, 32'd1);
      chk("to_err_early", {31'b0, fetch_err}, 32'd0);
    end
    step();
    chk("to_err_set", {31'b0, fetch_err}, 32'd1);
    chk("to_idle_noreq", {31'b0, imem_req}, 32'd0);
    step();
    chk("to_retry_req", {31'b0, imem_req}, 32'd1);
    chk("to_retry_addr", imem_addr, mpc);
    deliver("to_retry", 32'hC0DE_0099, 0, 0, 0, 0, 0, 0, mpc, mpc + 32'd4);
    chk("to_err_sticky", {31'b0, fetch_err}, 32'd1);

    // Reset while a response arrives on the same edge: nothing is captured.
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst = 1'b0;
    step();
    imem_ready = 1'b0;
    chk("mid_rst valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst instr", instr, 32'd0);
    chk("mid_rst instr_pc", instr_pc, 32'd0);
    chk("mid_rst err", {31'b0, fetch_err}, 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst reqaddr", imem_addr, 32'd0);

    // Branch backwards from 0 to the top of memory, then wrap sequentially.
    deliver("wrap_br", 32'h1000_FFFE, 0, 0, 0, 1, 0, 1, 32'h0, 32'hFFFF_FFFC);
    deliver("wrap_seq", 32'hC0DE_00FF, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0);

    mpc = 32'h0;
    for (int n = 0; n < 40; n++) begin
      w   = $urandom;
      rj  = ($urandom_range(0, 3) == 0);
      rb  = 1'($urandom);
      rne = 1'($urandom);
      rz  = 1'($urandom);
      nxt = ref_next(mpc, w, rj, rb, rne, rz);
      deliver("rand", w, $urandom_range(0, 3), $urandom_range(0, 3),
              rj, rb, rne, rz, mpc, nxt);
      mpc = nxt;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the single-cycle datapath top level.
- Holds the PC and requests instruction words from an instruction memory over a variable-latency req/ready handshake.
- Presents one instruction at a time to the datapath with a valid/ready handshake.
- Computes the next PC (sequential, beq/bne branch, j) from the datapath's iszero flag and decoded control at the moment the datapath consumes the instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- TIMEOUT, 16, cycles in REQ without imem_ready before fetch_err is raised; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low: rst==0 at a rising edge resets all state.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word address of the fetch; bits [1:0] always 0.
- imem_ready  in  1  memory response strobe; imem_rdata is valid while imem_ready==1 and imem_req==1.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  instruction presented to the datapath.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  datapath consumes instr this cycle.
- iszero  in  1  ALU zero flag for the instruction being consumed.
- branch_en  in  1  consumed instruction is a conditional branch.
- branch_ne  in  1  branch sense: 0 = beq (taken on iszero==1), 1 = bne (taken on iszero==0).
- jump_en  in  1  consumed instruction is j.
- fetch_err  out  1  sticky; a fetch exceeded TIMEOUT.

Behaviour:
- FSM states: IDLE, REQ, VALID.
- Reset (rst==0 at an edge):
  - state=IDLE, pc=RESET_PC.
  - instr=0, instr_pc=0, instr_valid=0, fetch_err=0, timeout counter=0.
  - imem_req=0 while in IDLE.
- IDLE: imem_req=0. Unconditionally moves to REQ next cycle; counter cleared.
- REQ: imem_req=1, imem_addr=pc.
  - If imem_ready==1: instr<=imem_rdata, instr_pc<=pc, go VALID.
  - Otherwise, counter increments.
  - If the counter reaches TIMEOUT with no ready: fetch_err<=1 and go IDLE, which retries the same pc. fetch_err stays 1 until reset.
  - Ready in the same cycle the count reaches TIMEOUT: capture wins; no error is raised.
- VALID: instr_valid=1, imem_req=0; instr/instr_pc held stable.
  - On instr_ready==1: pc<=next_pc, go REQ, counter cleared.
  - On instr_ready==0: hold indefinitely.
- instr_valid is 0 in IDLE and REQ. Exactly one instr_ready handshake per fetched word.
- instr_ready is ignored while instr_valid==0. branch_en, jump_en, iszero and branch_ne are sampled only on the handshake edge.
- next_pc, with pc4 = instr_pc + 4 (mod 2^32):
  - jump_en==1 (highest priority): {pc4[31:28], instr[25:0], 2'b00}.
  - else branch_en==1 and (iszero XOR branch_ne)==1: pc4 + (sign_extend(instr[15:0]) << 2), 32-bit wrap-around.
  - else: pc4.
- jump_en and branch_en both 1: jump wins.
- Latency:
  - Reset release at edge N: REQ visible in cycle N+1.
  - Zero-wait memory (ready in first REQ cycle): instr_valid in cycle N+2.
  - Steady state: 2 cycles per instruction (REQ, VALID) with zero-wait memory and instr_ready held high.
- Reset mid-operation (any state, including REQ with an outstanding request): immediately returns to IDLE. No capture occurs on that edge. Late imem_ready is ignored unless imem_req==1.
- PC wrap: pc4 from 32'hFFFF_FFFC is 32'h0000_0000.

Test Plan:
- Sequential fetch: RESET_PC=0, zero-wait memory returning addr-tagged words, instr_ready=1 -> instr_pc sequence 0,4,8,C; first instr_valid 2 cycles after reset release; imem_addr[1:0]==0 throughout.
- beq taken/not taken:
  - instr_pc=0x10, instr[15:0]=0xFFFE, branch_en=1, branch_ne=0, iszero=1 -> next fetch at 0x0C.
  - Same with iszero=0 -> next fetch at 0x14.
  - branch_ne=1, iszero=0 -> next fetch at 0x0C.
- Jump priority: instr_pc=0x3000_0000, instr[25:0]=26'h40, jump_en=1, branch_en=1, iszero=1 -> next fetch at 0x3000_0100.
- Backpressure and wait states:
  - imem_ready delayed 3 cycles -> instr_valid 4 cycles after REQ entry.
  - instr_ready low 5 cycles -> instr/instr_pc stable, no new imem_req.
- Timeout: TIMEOUT=4, imem_ready never asserted -> fetch_err=1 after 4 REQ cycles, IDLE for 1 cycle, REQ retried at the same pc; ready on the retry -> instr delivered, fetch_err stays 1.
- Mid-op reset and wrap:
  - rst=0 while in REQ with ready arriving same edge -> no capture, pc=RESET_PC, instr_valid=0.
  - instr_pc=0xFFFF_FFFC sequential -> next fetch at 0x0.
